// File: rtl/vga_defs.sv
// ---------------------------------------------------------------------------
// vga_defs
// Shared definitions for the VGA text-mode reader: 640x480@60 timing
// constants, text-grid geometry, pipeline depth, the raw sync bundle type
// and a byte-lane select helper.
// ---------------------------------------------------------------------------
package vga_defs;

  // Horizontal timing in pixel clocks.
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing in lines.
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

  // Both counters fit in 10 bits (max 799 / 524).
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
  localparam cnt_t H_VIS_END    = cnt_t'(H_VISIBLE);
  localparam cnt_t H_SYNC_START = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t H_SYNC_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);

  localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_VIS_END    = cnt_t'(V_VISIBLE);
  localparam cnt_t V_SYNC_START = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t V_SYNC_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Text grid geometry.
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int CELL_W    = 8;
  localparam int CELL_H    = 16;

  // Counter-to-pin latency in clocks.
  localparam int PIPE_LAT = 3;

  // Raw timing flags produced alongside the counters.
  typedef struct packed {
    logic hs;   // active low
    logic vs;   // active low
    logic vis;  // inside the 640x480 active area
    logic fs;   // counters at (0,0)
  } sync_t;

  // Value every stage of the sync delay line holds in reset.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, fs: 1'b0};

  // Select one byte lane of a 32-bit memory word; lane 0 is the low byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [1:0]  sel);
    return word[8*sel +: 8];
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// Free-running 800x525 raster counters with raw (undelayed) sync, visible
// and frame-start flags.
//
// Ports:
//   clk      in   pixel clock
//   clrn     in   asynchronous active-low reset
//   h_cnt_o  out  horizontal position 0..799
//   v_cnt_o  out  vertical position 0..524
//   sync_o   out  raw hs/vs (active low), visible, frame-start flags
// ---------------------------------------------------------------------------
module vga_sync_gen
  import vga_defs::*;
(
  input  logic  clk,
  input  logic  clrn,
  output cnt_t  h_cnt_o,
  output cnt_t  v_cnt_o,
  output sync_t sync_o
);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic h_wrap;

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment, so no path leaves it holding its old value
  // (which would infer a latch).
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + cnt_t'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o    = h_q;
  assign v_cnt_o    = v_q;
  assign sync_o.hs  = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
  assign sync_o.vs  = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
  assign sync_o.vis = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign sync_o.fs  = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_text_reader.sv
// ---------------------------------------------------------------------------
// vga_text_reader
// Read side of the VGA character memory: 640x480@60 timing, 80x30 text of
// 8x16 cells, one byte per character, font lookup through an external
// synchronous ROM, 12-bit RGB out. Counter-to-pin latency is 3 clocks and
// all outputs (RGB, syncs, frame_start) are mutually aligned.
//
// Pipeline:
//   T0  counters -> raddr (combinational)
//   T1  rdata byte lane -> font_addr (combinational from T1 registers)
//   T2  font_data bit select -> colour
//   T3  output registers
//
// Ports:
//   clk          in   25 MHz pixel clock (also memory / font ROM clock)
//   clrn         in   asynchronous active-low reset
//   raddr        out  13-bit byte address to character memory
//   rdata        in   containing 32-bit word, valid 1 clk after raddr
//   font_addr    out  {char, glyph_row} to font ROM
//   font_data    in   glyph row, valid 1 clk after font_addr, bit 7 leftmost
//   vga_hs/vs    out  syncs, active low
//   vga_r/g/b    out  4-bit colour channels
//   frame_start  out  one-clock pulse with pixel (0,0) on the pins
//   cursor_row   in   (VGA_CURSOR_EN only) cursor text row
//   cursor_col   in   (VGA_CURSOR_EN only) cursor text column
//
// Build option: define VGA_CURSOR_EN for a blinking underline cursor.
// ---------------------------------------------------------------------------
module vga_text_reader
  import vga_defs::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'd0,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clk,
  input  logic        clrn,
  output logic [12:0] raddr,
  input  logic [31:0] rdata,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
`ifdef VGA_CURSOR_EN
  ,
  input  logic [4:0]  cursor_row,
  input  logic [6:0]  cursor_col
`endif
);

  // ---------------- T0: raster counters and address ----------------
  cnt_t  h_cnt, v_cnt;
  sync_t sync_t0;

  vga_sync_gen u_sync_gen (
    .clk     (clk),
    .clrn    (clrn),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .sync_o  (sync_t0)
  );

  logic [5:0]  text_row;
  logic [6:0]  text_col;
  logic [12:0] text_addr;

  assign text_row  = v_cnt[9:4];
  assign text_col  = h_cnt[9:3];
  assign text_addr = BASE_ADDR + 13'(text_row) * 13'(TEXT_COLS) + 13'(text_col);

  // Gated by clrn as well so the pin reads 0 throughout reset even with a
  // nonzero BASE_ADDR.
  assign raddr = (sync_t0.vis && clrn) ? text_addr : '0;

  logic cursor_t0;

`ifdef VGA_CURSOR_EN
  // Counts completed frames; bit 5 gives a ~1.07 s blink with frames 0..31
  // of each 64 showing no cursor.
  logic [5:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = ((h_cnt == H_LAST) && (v_cnt == V_LAST)) ?
                       frame_cnt_q + 6'd1 : frame_cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  // Out-of-range cursor positions never match a visible cell. Glyph rows
  // 14-15 form the underline.
  assign cursor_t0 = frame_cnt_q[5] && sync_t0.vis &&
                     (text_row == {1'b0, cursor_row}) &&
                     (text_col == cursor_col) &&
                     (v_cnt[3:1] == 3'b111);
`else
  assign cursor_t0 = 1'b0;
`endif

  // ---------------- pipeline registers ----------------
  logic [1:0]  sel_q;      // byte lane of the T0 address
  logic [3:0]  grow_q;     // glyph row (v_cnt[3:0]) at T1
  logic [2:0]  hpix1_q;    // pixel within cell at T1
  logic [2:0]  hpix2_q;    // pixel within cell at T2
  sync_t       sync1_q, sync2_q;
  logic        cursor1_q, cursor2_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, vs_q, fs_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sel_q     <= '0;
      grow_q    <= '0;
      hpix1_q   <= '0;
      hpix2_q   <= '0;
      sync1_q   <= SYNC_IDLE;
      sync2_q   <= SYNC_IDLE;
      cursor1_q <= 1'b0;
      cursor2_q <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      sel_q     <= raddr[1:0];
      grow_q    <= v_cnt[3:0];
      hpix1_q   <= h_cnt[2:0];
      hpix2_q   <= hpix1_q;
      sync1_q   <= sync_t0;
      sync2_q   <= sync1_q;
      cursor1_q <= cursor_t0;
      cursor2_q <= cursor1_q;
      rgb_q     <= rgb_d;
      hs_q      <= sync2_q.hs;
      vs_q      <= sync2_q.vs;
      fs_q      <= sync2_q.fs;
    end
  end

  // ---------------- T1: character byte -> font address ----------------
  // The memory and font ROM each register their address, so driving
  // font_addr combinationally in T1 keeps the total latency at 3.
  logic [7:0] char_t1;

  assign char_t1   = pick_byte(rdata, sel_q);
  assign font_addr = clrn ? {char_t1, grow_q} : '0;

  // ---------------- T2: glyph bit -> colour ----------------
  logic pixel_t2;

  always_comb begin
    // Bit 7 is the leftmost pixel, so column x maps to bit (7 - x) = ~x.
    pixel_t2 = font_data[~hpix2_q] ^ cursor2_q;
    rgb_d    = '0;
    if (sync2_q.vis) begin
      rgb_d = pixel_t2 ? FG_COLOR : BG_COLOR;
    end
  end

  // ---------------- T3: pins ----------------
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign frame_start = fs_q;

endmodule

// File: doc/vga_text_reader.md
Name: vga_text_reader

Overview:
- Read-side companion of the CPU-writable VGA character memory. Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Fetches character codes from the memory read port (13-bit byte address; memory returns the containing 32-bit word) and looks up glyph rows in an external font ROM.
- Drives 12-bit RGB plus sync to the DAC pins.
- 80x30 text screen, 8x16 cells, one byte per character, byte 0 of each word is the leftmost character.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths (total 800)
- V_VISIBLE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths (total 525)
- BASE_ADDR, 13'd0, byte address of character (0,0)
- FG_COLOR, 12'hFFF, foreground RGB444
- BG_COLOR, 12'h000, background RGB444

Ports:
- clk  in  1  pixel clock, 25 MHz; also the memory rdclk and font ROM clock
- clrn  in  1  asynchronous active-low reset
- raddr  out  13  byte address to character memory read port
- rdata  in  32  word from memory, valid 1 cycle after raddr is sampled
- font_addr  out  12  {char[7:0], glyph_row[3:0]} to font ROM
- font_data  in  8  glyph row, valid 1 cycle after font_addr; bit 7 is the leftmost pixel
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_r / vga_g / vga_b  out  4 each  colour
- frame_start  out  1  one-cycle pulse aligned with the first output pixel (0,0)

Behaviour:
- Single clock domain.
- Reset (clrn=0, asynchronous) forces:
  - h_cnt=0, v_cnt=0, all pipeline registers cleared
  - vga_hs=1, vga_vs=1, RGB=0, raddr=0, font_addr=0, frame_start=0
- First counter position after reset release is (0,0).
- Counters: h_cnt 0..799 increments every clk and wraps to 0. v_cnt 0..524 increments when h_cnt wraps, and wraps 524->0 on the same edge that h_cnt wraps 799->0.
- Sync: hs low for h_cnt in [656,751]; vs low for v_cnt in [490,491]. visible = (h_cnt<640) && (v_cnt<480).
- Pipeline, stage T0 (counters):
  - raddr = BASE_ADDR + (v_cnt>>4)*80 + (h_cnt>>3), computed combinationally from the counters.
  - raddr = 0 when not visible.
  - Max visible address is BASE_ADDR+2399, truncated to 13 bits.
- Stage T1:
  - char = byte of rdata selected by the T0 raddr[1:0], registered one stage.
  - font_addr = {char, v_cnt[3:0] delayed 1}.
- Stage T2: pixel = font_data[7 - h_cnt[2:0] delayed 2].
- Stage T3 (output register):
  - RGB = pixel ? FG_COLOR : BG_COLOR when visible_d2, else 0.
  - hs/vs/visible/frame_start are delayed through the same 3-stage shift so every output is mutually aligned.
- Total latency counter->pins = 3 clk. Syncs are shifted 3 pixels relative to raw counters; the porches absorb this and this is the required behaviour.
- frame_start is high for exactly one cycle per 420000 cycles, on the cycle RGB shows pixel (0,0).
- Reset mid-frame: outputs go to reset values immediately; timing restarts at (0,0) and the pipeline refills (first 3 output cycles after release are blank/RGB=0).
- rdata and font_data are sampled every cycle with no handshake. The memory read port is never stalled; CPU writes on the other port are invisible to this block except through data content.

Optional Feature:
- VGA_CURSOR_EN defined:
  - Adds ports cursor_row in 5, cursor_col in 7.
  - A 6-bit frame counter increments on each frame_start; bit 5 is the blink phase (about 1.07 s period).
  - When the blink phase is 1, pixels in glyph rows 14-15 of cell (cursor_row, cursor_col) are inverted (FG<->BG).
  - cursor_row>=30 or cursor_col>=80 shows no cursor.
  - Frame counter resets to 0.
- VGA_CURSOR_EN not defined: ports and counter are absent; output is identical to the feature-on case with the cursor off-screen.

Decomposition:
- Shared header/package vga_defs:
  - timing constants (H_*/V_* totals, sync start/end)
  - TEXT_COLS=80, TEXT_ROWS=30, CELL_W=8, CELL_H=16
  - PIPE_LAT=3
- Sub-module vga_sync_gen: counters, hs/vs, visible, frame-start; outputs raw h_cnt/v_cnt.
- Address, byte-select, font and colour pipeline stay in vga_text_reader.

Test Plan:
- Reset then run 420000 cycles -> hs low 96 cycles every 800; vs low for exactly 2 lines every 525; frame_start exactly once, at pin-cycle for pixel (0,0).
- Memory model with word 0 = 32'h44434241, font model returning char itself -> cells 0..3 of row 0 show glyph rows of 0x41..0x44; raddr sequence 0 x8, 1 x8, 2 x8, 3 x8.
- Font model: 'A' row 0 = 8'b1000_0001 -> RGB at pin pixels (0,0) and (7,0) = 12'hFFF, (1..6,0) = 12'h000, appearing 3 cycles after counter position.
- h_cnt=639, v_cnt=479 -> raddr = BASE_ADDR+2399; next cycle raddr=0 and, 3 cycles later, RGB=0 during blanking.
- Assert clrn mid-line at h=300,v=200 -> same-cycle outputs hs=vs=1, RGB=0, raddr=0; after release, counters start at (0,0) and first nonzero RGB appears no earlier than cycle 3.
- (VGA_CURSOR_EN) cursor (2,5), 32 frames elapsed -> pixels x=40..47, y=46..47 inverted; frames 0..31 uncovered; cursor_col=80 -> never inverted.
